// File: rtl/tin_filter.sv
// tin_filter: timer input conditioning for one capture channel.
// Two-flop synchroniser, prescaled N-consecutive-sample glitch filter,
// filtered level output and single-cycle rise/fall/capture pulses.
// Optional macro TIN_GLITCH_CNT_EN adds a saturating rejected-glitch
// counter (glitch_cnt) with a clear input (glitch_clr).
module tin_filter #(
  parameter int PSC_BITS = 8,
  parameter int FN_BITS  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                t_in,
  input  logic                en,
  input  logic [PSC_BITS-1:0] fdiv,
  input  logic [FN_BITS-1:0]  fn,
  input  logic [1:0]          edge_sel,
`ifdef TIN_GLITCH_CNT_EN
  input  logic                glitch_clr,
  output logic [7:0]          glitch_cnt,
`endif
  output logic                t_filt,
  output logic                rise_pulse,
  output logic                fall_pulse,
  output logic                cap_evt
);

  logic                sync1_q, sync2_q;
  logic [PSC_BITS-1:0] div_cnt_q, div_cnt_d;
  logic [FN_BITS-1:0]  run_cnt_q, run_cnt_d;
  logic                t_filt_q, t_filt_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;
  logic                cap_q, cap_d;

  logic                tick;
  logic                differ;
  logic                accept;
  logic                glitch_evt;
  logic [FN_BITS-1:0]  fn_eff;
  logic [FN_BITS:0]    run_inc;

  // A sample tick is due once the divider reaches (or has passed) fdiv;
  // the >= compare recovers immediately when fdiv is lowered mid-count.
  assign tick    = en && (div_cnt_q >= fdiv);
  assign fn_eff  = (fn == '0) ? FN_BITS'(1) : fn;
  assign run_inc = {1'b0, run_cnt_q} + (FN_BITS + 1)'(1);
  assign differ  = (sync2_q != t_filt_q);
  // A new level is accepted when the run of differing samples is long enough.
  // Comparing against the live fn lets a lowered fn take effect at once.
  assign accept  = tick && differ && (run_inc >= {1'b0, fn_eff});
  // A run cut short by a matching sample is a rejected glitch.
  assign glitch_evt = tick && !differ && (run_cnt_q != '0);

  // Next-state logic for divider, run counter, level and edge pulses.
  always_comb begin
    div_cnt_d = div_cnt_q;
    run_cnt_d = run_cnt_q;
    t_filt_d  = t_filt_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    cap_d     = 1'b0;
    if (!en) begin
      div_cnt_d = '0;
      run_cnt_d = '0;
    end else begin
      div_cnt_d = tick ? '0 : div_cnt_q + PSC_BITS'(1);
      if (tick) begin
        if (!differ) begin
          run_cnt_d = '0;
        end else if (accept) begin
          run_cnt_d = '0;
          t_filt_d  = sync2_q;
          rise_d    = sync2_q;
          fall_d    = !sync2_q;
        end else begin
          run_cnt_d = run_inc[FN_BITS-1:0];
        end
      end
    end
    cap_d = (rise_d & edge_sel[0]) | (fall_d & edge_sel[1]);
  end

  // Two-flop synchroniser for the asynchronous pin; independent of en.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= t_in;
      sync2_q <= sync1_q;
    end
  end

  // Sample divider and consecutive-sample run counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      run_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  // Filtered level and its registered edge/capture pulses, updated together
  // so each pulse is high in the first cycle the new level is visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_filt_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      cap_q    <= 1'b0;
    end else begin
      t_filt_q <= t_filt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      cap_q    <= cap_d;
    end
  end

  assign t_filt     = t_filt_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign cap_evt    = cap_q;

`ifdef TIN_GLITCH_CNT_EN
  logic [7:0] glitch_cnt_q;

  // Saturating count of rejected glitches; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_cnt_q <= 8'd0;
    end else if (glitch_clr) begin
      glitch_cnt_q <= 8'd0;
    end else if (glitch_evt && (glitch_cnt_q != 8'hFF)) begin
      glitch_cnt_q <= glitch_cnt_q + 8'd1;
    end
  end

  assign glitch_cnt = glitch_cnt_q;
`else
  logic unused_glitch;
  assign unused_glitch = glitch_evt;
`endif

endmodule
